// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute stage that sits behind the 64x16 register file. It latches the
//   two read operands on a Start request, computes a result either in a
//   single EXEC cycle or in a multi-cycle shift-add multiplier, and presents
//   the result on the register file write port for one WB cycle.
//
//   Optional feature macro: ALU_MUL_EN
//     defined   : MUL state and shift-add datapath present (opcode 8 = MUL)
//     undefined : no multiplier; opcode 8 reports IllegalOp via EXEC
//
// Ports:
//   Clock, nReset          clock (rising edge), async active-low reset
//   Start                  request, accepted when the unit is free
//   Opcode, DestAddr       operation / writeback register, latched on accept
//   OperandA, OperandB     register file read data, latched on accept
//   Busy                   high from the cycle after accept through WB
//   Done                   one-cycle pulse in WB
//   WriteEnable            one-cycle pulse in WB for result-producing ops
//   WriteAddress/WriteData writeback address/data, held outside WB
//   FlagZ, FlagC, FlagN    zero, carry/borrow, negative
//   IllegalOp              pulses with Done for unsupported opcodes
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  Start,
  input  logic [3:0]            Opcode,
  input  logic [ADDR_WIDTH-1:0] DestAddr,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  output logic                  Busy,
  output logic                  Done,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  FlagZ,
  output logic                  FlagC,
  output logic                  FlagN,
  output logic                  IllegalOp
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]            r_opcode;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;

  logic                      w_accept;
  logic                      w_mul_en;
  logic                      w_mul_last;
  logic [2*DATA_WIDTH-1:0]   w_prod;
  logic [DATA_WIDTH:0]       w_add;
  logic [DATA_WIDTH:0]       w_sub;
  logic [2*DATA_WIDTH-1:0]   w_shl;
  logic [2*DATA_WIDTH-1:0]   w_shr;
  logic [DATA_WIDTH-1:0]     w_res;
  logic                      w_carry;
  logic                      w_writes;
  logic                      w_illegal;

  // A new request is taken in IDLE or at the edge that ends WB (back-to-back).
  assign w_accept = Start && ((r_state == ST_IDLE) || (r_state == ST_WB));

  // Wide arithmetic so carry/borrow and shifted-out bits fall out directly.
  assign w_add = {1'b0, r_a} + {1'b0, r_b};
  assign w_sub = {1'b0, r_a} - {1'b0, r_b};
  assign w_shl = {{DATA_WIDTH{1'b0}}, r_a} << r_b[3:0];
  assign w_shr = {r_a, {DATA_WIDTH{1'b0}}} >> r_b[3:0];

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [2*DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0]   r_mplier;
  logic [2*DATA_WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]        r_cnt;

  assign w_mul_en = 1'b1;
  // DATA_WIDTH shift-add iterations, then one extra cycle to hand off the product.
  assign w_mul_last = (r_cnt == CNT_W'(DATA_WIDTH));
  assign w_prod = r_prod;

  // Shift-add multiplier datapath.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_mcand  <= {(2*DATA_WIDTH){1'b0}};
      r_mplier <= {DATA_WIDTH{1'b0}};
      r_prod   <= {(2*DATA_WIDTH){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_mcand  <= {{DATA_WIDTH{1'b0}}, OperandA};
      r_mplier <= OperandB;
      r_prod   <= {(2*DATA_WIDTH){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if ((r_state == ST_MUL) && !w_mul_last) begin
      if (r_mplier[0]) begin
        r_prod <= r_prod + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_mul_en   = 1'b0;
  assign w_mul_last = 1'b1;
  assign w_prod     = {(2*DATA_WIDTH){1'b0}};
`endif

  // Operand / control latch on accept.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_opcode <= 4'd0;
      r_dest   <= {ADDR_WIDTH{1'b0}};
      r_a      <= {DATA_WIDTH{1'b0}};
      r_b      <= {DATA_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_opcode <= Opcode;
      r_dest   <= DestAddr;
      r_a      <= OperandA;
      r_b      <= OperandB;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_WB: begin
        if (w_accept) begin
          w_state_nxt = ((Opcode == OP_MUL) && w_mul_en) ? ST_MUL : ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_MUL: begin
        if (w_mul_last) begin
          w_state_nxt = ST_WB;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle result, carry and op classification.
  always_comb begin
    w_res     = {DATA_WIDTH{1'b0}};
    w_carry   = 1'b0;
    w_writes  = 1'b1;
    w_illegal = 1'b0;
    case (r_opcode)
      OP_ADD: begin w_res = w_add[DATA_WIDTH-1:0]; w_carry = w_add[DATA_WIDTH]; end
      OP_SUB: begin w_res = w_sub[DATA_WIDTH-1:0]; w_carry = w_sub[DATA_WIDTH]; end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_SHL: begin w_res = w_shl[DATA_WIDTH-1:0]; w_carry = w_shl[DATA_WIDTH]; end
      OP_SHR: begin w_res = w_shr[2*DATA_WIDTH-1:DATA_WIDTH]; w_carry = w_shr[DATA_WIDTH-1]; end
      OP_MOV: w_res = r_b;
      OP_NOP: w_writes = 1'b0;
      // MUL only reaches EXEC when the multiplier is not built in.
      OP_MUL: begin w_writes = 1'b0; w_illegal = 1'b1; end
      default: begin w_writes = 1'b0; w_illegal = 1'b1; end
    endcase
  end

  // Registered handshake, writeback port and flags.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Busy         <= 1'b0;
      Done         <= 1'b0;
      WriteEnable  <= 1'b0;
      IllegalOp    <= 1'b0;
      WriteAddress <= {ADDR_WIDTH{1'b0}};
      WriteData    <= {DATA_WIDTH{1'b0}};
      FlagZ        <= 1'b0;
      FlagC        <= 1'b0;
      FlagN        <= 1'b0;
    end else begin
      Busy        <= (w_state_nxt != ST_IDLE);
      Done        <= (w_state_nxt == ST_WB);
      WriteEnable <= 1'b0;
      IllegalOp   <= 1'b0;
      if (r_state == ST_EXEC) begin
        IllegalOp <= w_illegal;
        if (w_writes) begin
          WriteEnable  <= 1'b1;
          WriteAddress <= r_dest;
          WriteData    <= w_res;
          FlagZ        <= (w_res == {DATA_WIDTH{1'b0}});
          FlagC        <= w_carry;
          FlagN        <= w_res[DATA_WIDTH-1];
        end
      end else if ((r_state == ST_MUL) && w_mul_last) begin
        WriteEnable  <= 1'b1;
        WriteAddress <= r_dest;
        WriteData    <= w_prod[DATA_WIDTH-1:0];
        FlagZ        <= (w_prod[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
        FlagC        <= |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        FlagN        <= w_prod[DATA_WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Randomised + directed bench for alu_exec_unit. The driver pushes the
//   expected WB response (cycle, write port, flags, IllegalOp) into a queue
//   when a request is accepted; a monitor pops and compares whenever Done is
//   seen, and checks Busy / stray write pulses every cycle.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  localparam int DW = 16;
  localparam int AW = 6;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          Clock;
  logic          nReset;
  logic          Start;
  logic [3:0]    Opcode;
  logic [AW-1:0] DestAddr;
  logic [DW-1:0] OperandA;
  logic [DW-1:0] OperandB;
  logic          Busy;
  logic          Done;
  logic          WriteEnable;
  logic [AW-1:0] WriteAddress;
  logic [DW-1:0] WriteData;
  logic          FlagZ;
  logic          FlagC;
  logic          FlagN;
  logic          IllegalOp;

  alu_exec_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .Opcode(Opcode),
    .DestAddr(DestAddr), .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done), .WriteEnable(WriteEnable),
    .WriteAddress(WriteAddress), .WriteData(WriteData),
    .FlagZ(FlagZ), .FlagC(FlagC), .FlagN(FlagN), .IllegalOp(IllegalOp)
  );

  typedef struct {
    int unsigned cyc;
    bit          we;
    int unsigned addr;
    int unsigned data;
    bit          z;
    bit          c;
    bit          n;
    bit          ill;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned free_edge = 0;
  int unsigned last_acc = 0;
  int unsigned m_addr = 0;
  int unsigned m_data = 0;
  bit          m_z = 1'b0;
  bit          m_c = 1'b0;
  bit          m_n = 1'b0;
  bit          started = 1'b0;
  bit          acc;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: applies the operation rules with plain arithmetic and
  // records what the WB cycle must look like. Accept edge e.
  task automatic model_issue(input int unsigned e, input int unsigned op,
                             input int unsigned dest, input int unsigned a,
                             input int unsigned b);
    int unsigned      res = 0;
    int unsigned      c = 0;
    int unsigned      sh = b % 16;
    int unsigned      lat = 2;
    bit               wr = 1'b1;
    bit               ill = 1'b0;
    longint unsigned  p;
    case (op)
      0: begin res = (a + b) % 65536; c = (a + b) / 65536; end
      1: begin res = (a + 65536 - b) % 65536; c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = 65535 - a;
      6: begin res = (a << sh) % 65536; c = (sh == 0) ? 0 : (a >> (16 - sh)) & 1; end
      7: begin res = a >> sh; c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
      8: begin
        if (MUL_EN) begin
          p = longint'(a) * longint'(b);
          res = int'(p % 65536);
          c = ((p / 65536) != 0) ? 1 : 0;
          lat = DW + 2;
        end else begin
          wr = 1'b0; ill = 1'b1;
        end
      end
      9: res = b;
      15: wr = 1'b0;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
    if (wr) begin
      m_data = res; m_addr = dest; m_c = c[0];
      m_z = (res == 0); m_n = res[15];
    end
    q.push_back('{cyc: e + lat - 1, we: wr, addr: m_addr, data: m_data,
                  z: m_z, c: m_c, n: m_n, ill: ill});
    last_acc  = e;
    free_edge = e + lat;
  endtask

  // Drive one cycle of inputs; report whether the request gets accepted.
  task automatic cycle_drive(input bit st, input int unsigned op, input int unsigned dest,
                             input int unsigned a, input int unsigned b, output bit accepted);
    @(negedge Clock);
    Start = st; Opcode = op[3:0]; DestAddr = dest[AW-1:0];
    OperandA = a[DW-1:0]; OperandB = b[DW-1:0];
    accepted = 1'b0;
    if (st && nReset && (cyc + 1 >= free_edge)) begin
      model_issue(cyc + 1, op, dest % 64, a % 65536, b % 65536);
      accepted = 1'b1;
    end
  endtask

  task automatic wait_free();
    bit dummy;
    for (int i = 0; i < 40 && (cyc + 1 < free_edge); i++) begin
      cycle_drive(1'b0, 0, 0, 0, 0, dummy);
    end
  endtask

  task automatic run_op(input int unsigned op, input int unsigned dest,
                        input int unsigned a, input int unsigned b);
    bit a_ok;
    cycle_drive(1'b1, op, dest, a, b, a_ok);
    chk("accept", a_ok, 1);
    wait_free();
  endtask

  // Monitor: Busy every cycle, WB contents on Done, no stray pulses otherwise.
  always @(posedge Clock) begin
    #1;
    if (nReset && started) begin
      chk("busy", Busy, (cyc >= last_acc && cyc < free_edge) ? 1 : 0);
      if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("missed_done", 0, 1);
        void'(q.pop_front());
      end
      if (Done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", cyc, mon_e.cyc);
          chk("write_enable", WriteEnable, mon_e.we);
          chk("write_address", WriteAddress, mon_e.addr);
          chk("write_data", WriteData, mon_e.data);
          chk("flag_z", FlagZ, mon_e.z);
          chk("flag_c", FlagC, mon_e.c);
          chk("flag_n", FlagN, mon_e.n);
          chk("illegal_op", IllegalOp, mon_e.ill);
        end
      end else begin
        chk("we_outside_wb", WriteEnable, 0);
        chk("illegal_outside_wb", IllegalOp, 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_done"}, Done, 0);
    chk({tag, "_we"}, WriteEnable, 0);
    chk({tag, "_ill"}, IllegalOp, 0);
    chk({tag, "_waddr"}, WriteAddress, 0);
    chk({tag, "_wdata"}, WriteData, 0);
    chk({tag, "_flags"}, {FlagZ, FlagC, FlagN}, 0);
  endtask

  initial begin
    Start = 1'b0; Opcode = 4'd0; DestAddr = '0; OperandA = '0; OperandB = '0;
    nReset = 1'b0;
    @(negedge Clock);
    chk_all_zero("reset");
    @(negedge Clock);
    nReset = 1'b1;
    started = 1'b1;

    // ADD with carry-out to zero
    run_op(0, 12, 16'hFFFF, 16'h0001);

    // SUB then SHL back-to-back with Start held high
    cycle_drive(1'b1, 1, 5, 16'h0003, 16'h0005, acc);
    chk("sub_accept", acc, 1);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      cycle_drive(1'b1, 6, 7, 16'h8001, 4, acc);
    end
    chk("shl_accept", acc, 1);
    wait_free();

    // MUL (or illegal without the multiplier); Start pulses while busy ignored
    cycle_drive(1'b1, 8, 3, 16'h0123, 16'h0100, acc);
    chk("mul_accept", acc, 1);
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b1, 0, 9, $urandom, $urandom, acc);
    end
    wait_free();

    // Illegal, NOP and opcode 8
    run_op(12, 40, 16'h1234, 16'h4321);
    run_op(15, 41, 16'h0000, 16'h0000);
    run_op(8, 42, 16'h0007, 16'h0009);
    run_op(7, 1, 16'h8001, 16'h0000);
    run_op(7, 2, 16'h0003, 16'h0001);

    // Reset in the middle of an operation aborts it with no write
    cycle_drive(1'b1, 8, 20, 3, 5, acc);
    chk("rst_op_accept", acc, 1);
    for (int i = 0; i < (MUL_EN ? 4 : 1); i++) begin
      cycle_drive(1'b0, 0, 0, 0, 0, acc);
    end
    Start = 1'b0;
    nReset = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    q.delete();
    free_edge = 0; last_acc = 0;
    m_addr = 0; m_data = 0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    run_op(3, 33, 16'h0F00, 16'h00F0);

    // Random traffic: Start often held across busy periods
    for (int i = 0; i < 500; i++) begin
      cycle_drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 63),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535),
                  ($urandom_range(0, 7) == 0) ? 16'hFFFF : $urandom_range(0, 65535), acc);
    end
    Start = 1'b0;
    wait_free();
    repeat (2) @(negedge Clock);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
